// File: rtl/sdram_device_responder.sv
// -----------------------------------------------------------------------------
// sdram_device_responder
//
// Device-side model of a single 16-bit SDRAM chip, meant to sit opposite an
// SDRAM controller in simulation and FPGA loopback benches. It decodes the
// CS/RAS/CAS/WE command bus, walks the power-up init sequence, tracks the mode
// register (CAS latency) and the open row of each of the four banks, services
// single-word READ/WRITE from an internal block-RAM array, and latches the
// first protocol violation seen since reset.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   sd_cs        chip select, active low (1 = deselect, treated as NOP)
//   sd_bank      bank address
//   sd_addr      row (ACT) / column (RD/WR) / A10 all-banks (PRE) / mode (MRS)
//   sd_ras/cas/we command bits {ras,cas,we}
//   sd_data_in   write data
//   sd_data_out  read data (0 when not valid)
//   sd_data_oe   read data valid / bus drive
//   init_done    init sequence completed
//   mode_cl      current CAS latency (2 or 3)
//   err          sticky protocol-error flag
//   err_code     code of the first error since reset
//
// Configuration
//   SDRAM_TIMING_CHECK_EN  when defined, per-bank tRCD/tRP/tRC checking is
//                          added (codes 6/7/8). Violating commands still
//                          execute. Undefined: no timing checks.
// -----------------------------------------------------------------------------
module sdram_device_responder #(
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10,
    parameter int MEM_ROW_W = 4,
    parameter int TRCD      = 3,
    parameter int TRP       = 2,
    parameter int TRC       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sd_cs,
    input  logic [1:0]       sd_bank,
    input  logic [ROW_W-1:0] sd_addr,
    input  logic             sd_ras,
    input  logic             sd_cas,
    input  logic             sd_we,
    input  logic [15:0]      sd_data_in,
    output logic [15:0]      sd_data_out,
    output logic             sd_data_oe,
    output logic             init_done,
    output logic [2:0]       mode_cl,
    output logic             err,
    output logic [3:0]       err_code
);

    localparam int MEM_AW    = 2 + MEM_ROW_W + COL_W;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam logic [3:0] ERR_UNINIT    = 4'd1;
    localparam logic [3:0] ERR_CLOSED    = 4'd2;
    localparam logic [3:0] ERR_OPEN      = 4'd3;
    localparam logic [3:0] ERR_NOT_IDLE  = 4'd4;
    localparam logic [3:0] ERR_BAD_CL    = 4'd5;

    typedef enum logic [2:0] {
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_MRS,
        ST_READY
    } init_state_t;

    init_state_t                 init_reg, init_next;
    logic [3:0]                  open_reg, open_next;
    logic [3:0][MEM_ROW_W-1:0]   row_reg, row_next;
    logic [2:0]                  cl_reg, cl_next;
    logic                        err_reg;
    logic [3:0]                  err_code_reg;
    logic                        err_hit;
    logic [3:0]                  err_hit_code;
    logic                        mem_we, mem_re;
    logic [MEM_AW-1:0]           mem_addr;
    logic [2:0]                  cmd;
    logic                        mrs_cl_ok;

    // The unassigned encoding 110 (burst stop on real parts) has no meaning
    // with BL=1, so it is folded into NOP together with deselect.
    assign cmd = (sd_cs || ({sd_ras, sd_cas, sd_we} == 3'b110)) ? CMD_NOP
                                                               : {sd_ras, sd_cas, sd_we};
    assign mrs_cl_ok = (sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3);
    assign mem_addr  = {sd_bank, row_reg[sd_bank], sd_addr[COL_W-1:0]};

    // Row bits above A10 are never interpreted by this model.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{1'b0, sd_addr[ROW_W-1:COL_W+1]};

`ifdef SDRAM_TIMING_CHECK_EN
    localparam logic [3:0] TRCD_C = 4'(TRCD);
    localparam logic [3:0] TRP_C  = 4'(TRP);
    localparam logic [3:0] TRC_C  = 4'(TRC);

    // Each counter holds the number of edges since the last ACT/PRE to that
    // bank (1 on the edge after the command), saturating at 15.
    logic [3:0][3:0] act_cnt_reg, pre_cnt_reg;
    logic [3:0]      act_hit, pre_hit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank_timer
            assign act_hit[gi] = (init_reg == ST_READY) && (cmd == CMD_ACT)
                              && (sd_bank == 2'(gi));
            assign pre_hit[gi] = (init_reg == ST_READY) && (cmd == CMD_PRE)
                              && (sd_addr[10] || (sd_bank == 2'(gi)));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    act_cnt_reg[gi] <= 4'hF;
                    pre_cnt_reg[gi] <= 4'hF;
                end else begin
                    if (act_hit[gi])
                        act_cnt_reg[gi] <= 4'd1;
                    else if (act_cnt_reg[gi] != 4'hF)
                        act_cnt_reg[gi] <= act_cnt_reg[gi] + 4'd1;
                    if (pre_hit[gi])
                        pre_cnt_reg[gi] <= 4'd1;
                    else if (pre_cnt_reg[gi] != 4'hF)
                        pre_cnt_reg[gi] <= pre_cnt_reg[gi] + 4'd1;
                end
            end
        end
    endgenerate
`else
    logic unused_timing_params;
    assign unused_timing_params = ^{4'(TRCD), 4'(TRP), 4'(TRC)};
`endif

    // Command decode: next init/bank/mode state, error event, array strobes.
    always_comb begin
        init_next    = init_reg;
        open_next    = open_reg;
        row_next     = row_reg;
        cl_next      = cl_reg;
        err_hit      = 1'b0;
        err_hit_code = 4'd0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        case (init_reg)
            ST_INIT_PRE: begin
                if (cmd == CMD_PRE) init_next = ST_INIT_REF1;
                else if (cmd != CMD_NOP) begin err_hit = 1'b1; err_hit_code = ERR_UNINIT; end
            end
            ST_INIT_REF1: begin
                if (cmd == CMD_REF) init_next = ST_INIT_REF2;
                else if (cmd != CMD_NOP) begin err_hit = 1'b1; err_hit_code = ERR_UNINIT; end
            end
            ST_INIT_REF2: begin
                if (cmd == CMD_REF) init_next = ST_INIT_MRS;
                else if (cmd != CMD_NOP) begin err_hit = 1'b1; err_hit_code = ERR_UNINIT; end
            end
            ST_INIT_MRS: begin
                if (cmd == CMD_MRS) begin
                    init_next = ST_READY;
                    if (mrs_cl_ok) cl_next = sd_addr[6:4];
                    else begin err_hit = 1'b1; err_hit_code = ERR_BAD_CL; end
                end else if (cmd != CMD_NOP) begin
                    err_hit = 1'b1; err_hit_code = ERR_UNINIT;
                end
            end
            default: begin // ST_READY
                case (cmd)
                    CMD_ACT: begin
                        if (open_reg[sd_bank]) begin
                            err_hit = 1'b1; err_hit_code = ERR_OPEN;
                        end
`ifdef SDRAM_TIMING_CHECK_EN
                        else if (pre_cnt_reg[sd_bank] < TRP_C) begin
                            err_hit = 1'b1; err_hit_code = 4'd7;
                        end else if (act_cnt_reg[sd_bank] < TRC_C) begin
                            err_hit = 1'b1; err_hit_code = 4'd8;
                        end
`endif
                        open_next[sd_bank] = 1'b1;
                        row_next[sd_bank]  = sd_addr[MEM_ROW_W-1:0];
                    end
                    CMD_RD, CMD_WR: begin
                        if (!open_reg[sd_bank]) begin
                            err_hit = 1'b1; err_hit_code = ERR_CLOSED;
                        end else begin
`ifdef SDRAM_TIMING_CHECK_EN
                            if (act_cnt_reg[sd_bank] < TRCD_C) begin
                                err_hit = 1'b1; err_hit_code = 4'd6;
                            end
`endif
                            mem_we = (cmd == CMD_WR);
                            mem_re = (cmd == CMD_RD);
                        end
                    end
                    CMD_PRE: begin
                        if (sd_addr[10]) open_next = 4'b0000;
                        else             open_next[sd_bank] = 1'b0;
                    end
                    CMD_REF: begin
                        if (|open_reg) begin err_hit = 1'b1; err_hit_code = ERR_NOT_IDLE; end
                    end
                    CMD_MRS: begin
                        if (|open_reg) begin
                            err_hit = 1'b1; err_hit_code = ERR_NOT_IDLE;
                        end else if (mrs_cl_ok) begin
                            cl_next = sd_addr[6:4];
                        end else begin
                            err_hit = 1'b1; err_hit_code = ERR_BAD_CL;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_reg     <= ST_INIT_PRE;
            open_reg     <= 4'b0000;
            row_reg      <= '0;
            cl_reg       <= 3'd2;
            err_reg      <= 1'b0;
            err_code_reg <= 4'd0;
        end else begin
            init_reg <= init_next;
            open_reg <= open_next;
            row_reg  <= row_next;
            cl_reg   <= cl_next;
            if (err_hit && !err_reg) begin
                err_reg      <= 1'b1;
                err_code_reg <= err_hit_code;
            end
        end
    end

    // Storage array: no reset so it maps to block RAM and keeps contents
    // across reset. The read is registered at the RD edge, so a WR issued on
    // the following edge cannot disturb the word already captured.
    logic [15:0] mem [MEM_DEPTH];
    logic [15:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= sd_data_in;
        if (mem_re) rd_data_reg <= mem[mem_addr];
    end

    // Read return pipeline. Stage 1 is valid on the edge after the RD; CL=2
    // reads drive the output register from there, CL=3 reads go through one
    // extra stage. Each read carries the CL in force when it was issued. The
    // output register is loaded at edge k+CL-1, so data is on the bus during
    // the cycle that ends at edge k+CL.
    logic        s1_valid_reg, s1_cl3_reg;
    logic        s2_valid_reg;
    logic [15:0] s2_data_reg;
    logic [15:0] data_out_reg;
    logic        data_oe_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_cl3_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= 16'd0;
            data_out_reg <= 16'd0;
            data_oe_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= mem_re;
            s1_cl3_reg   <= (cl_reg == 3'd3);
            s2_valid_reg <= s1_valid_reg && s1_cl3_reg;
            s2_data_reg  <= rd_data_reg;
            if (s1_valid_reg && !s1_cl3_reg) begin
                data_out_reg <= rd_data_reg;
                data_oe_reg  <= 1'b1;
            end else if (s2_valid_reg) begin
                data_out_reg <= s2_data_reg;
                data_oe_reg  <= 1'b1;
            end else begin
                data_out_reg <= 16'd0;
                data_oe_reg  <= 1'b0;
            end
        end
    end

    assign sd_data_out = data_out_reg;
    assign sd_data_oe  = data_oe_reg;
    assign init_done   = (init_reg == ST_READY);
    assign mode_cl     = cl_reg;
    assign err         = err_reg;
    assign err_code    = err_code_reg;

endmodule

// File: tb/tb_sdram_device_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_device_responder
//
// Directed self-checking bench for sdram_device_responder. Commands are driven
// on the falling edge so the DUT samples them on the following rising edge;
// outputs are sampled on falling edges. Every expected value is written
// directly from the command timing (RD at edge k, data during the cycle that
// ends at edge k+CL).
// -----------------------------------------------------------------------------
module tb_sdram_device_responder;

    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

`ifdef SDRAM_TIMING_CHECK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sd_cs;
    logic [1:0]  sd_bank;
    logic [12:0] sd_addr;
    logic        sd_ras, sd_cas, sd_we;
    logic [15:0] sd_data_in;
    logic [15:0] sd_data_out;
    logic        sd_data_oe;
    logic        init_done;
    logic [2:0]  mode_cl;
    logic        err;
    logic [3:0]  err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_device_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sd_cs      (sd_cs),
        .sd_bank    (sd_bank),
        .sd_addr    (sd_addr),
        .sd_ras     (sd_ras),
        .sd_cas     (sd_cas),
        .sd_we      (sd_we),
        .sd_data_in (sd_data_in),
        .sd_data_out(sd_data_out),
        .sd_data_oe (sd_data_oe),
        .init_done  (init_done),
        .mode_cl    (mode_cl),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] b,
                         input logic [12:0] a, input logic [15:0] d);
        @(negedge clk);
        sd_cs      = 1'b0;
        {sd_ras, sd_cas, sd_we} = c;
        sd_bank    = b;
        sd_addr    = a;
        sd_data_in = d;
    endtask

    task automatic nop();
        drive(C_NOP, 2'd0, 13'd0, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sd_cs   = 1'b1;
        {sd_ras, sd_cas, sd_we} = C_NOP;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic do_init();
        drive(C_PRE, 2'd0, 13'h400, 16'd0);
        drive(C_REF, 2'd0, 13'd0, 16'd0);
        drive(C_REF, 2'd0, 13'd0, 16'd0);
        drive(C_MRS, 2'd0, 13'h220, 16'd0);
        nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        sd_cs      = 1'b1;
        {sd_ras, sd_cas, sd_we} = C_NOP;
        sd_bank    = 2'd0;
        sd_addr    = 13'd0;
        sd_data_in = 16'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_oe", sd_data_oe, 0);
        check("rst_dout", sd_data_out, 0);
        check("rst_init", init_done, 0);
        check("rst_cl", mode_cl, 2);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        reset_n = 1'b1;

        // 1: init sequence
        drive(C_PRE, 2'd0, 13'h400, 16'd0);
        drive(C_REF, 2'd0, 13'd0, 16'd0);
        drive(C_REF, 2'd0, 13'd0, 16'd0);
        drive(C_MRS, 2'd0, 13'h220, 16'd0);
        check("init_not_yet", init_done, 0);
        nop();
        check("init_done", init_done, 1);
        check("init_cl", mode_cl, 2);
        check("init_err", err, 0);

        // 2: ACT, WR, RD with CL=2
        drive(C_ACT, 2'd1, 13'd5, 16'd0);
        nop(); nop(); nop();
        drive(C_WR, 2'd1, 13'h010, 16'hBEEF);
        drive(C_RD, 2'd1, 13'h010, 16'd0);
        nop();
        check("cl2_oe_e1", sd_data_oe, 0);
        nop();
        check("cl2_oe_e2", sd_data_oe, 1);
        check("cl2_data", sd_data_out, 16'hBEEF);
        nop();
        check("cl2_oe_after", sd_data_oe, 0);
        check("cl2_dout_after", sd_data_out, 0);

        // back-to-back RDs, WR to second address right after the second RD
        drive(C_WR, 2'd1, 13'h011, 16'h1234);
        drive(C_RD, 2'd1, 13'h010, 16'd0);
        drive(C_RD, 2'd1, 13'h011, 16'd0);
        drive(C_WR, 2'd1, 13'h011, 16'h5678);
        check("b2b_oe1", sd_data_oe, 1);
        check("b2b_data1", sd_data_out, 16'hBEEF);
        nop();
        check("b2b_oe2", sd_data_oe, 1);
        check("b2b_old_data", sd_data_out, 16'h1234);
        nop();
        check("b2b_oe_end", sd_data_oe, 0);
        drive(C_RD, 2'd1, 13'h011, 16'd0);
        nop(); nop();
        check("wr_landed", sd_data_out, 16'h5678);
        check("t2_err", err, 0);

        // 3: CL=3 then illegal CL=5
        drive(C_PRE, 2'd0, 13'h400, 16'd0);
        drive(C_MRS, 2'd0, 13'h030, 16'd0);
        nop();
        check("mrs_cl3", mode_cl, 3);
        check("mrs_cl3_err", err, 0);
        drive(C_ACT, 2'd1, 13'd5, 16'd0);
        nop(); nop(); nop();
        drive(C_RD, 2'd1, 13'h010, 16'd0);
        nop();
        check("cl3_oe_e1", sd_data_oe, 0);
        nop();
        check("cl3_oe_e2", sd_data_oe, 0);
        nop();
        check("cl3_oe_e3", sd_data_oe, 1);
        check("cl3_data", sd_data_out, 16'hBEEF);
        nop();
        check("cl3_oe_after", sd_data_oe, 0);
        drive(C_PRE, 2'd0, 13'h400, 16'd0);
        drive(C_MRS, 2'd0, 13'h050, 16'd0);
        nop();
        check("bad_cl_err", err, 1);
        check("bad_cl_code", err_code, 5);
        check("bad_cl_kept", mode_cl, 3);

        // 4: RD before init, then RD to closed bank
        do_reset();
        check("rst2_err", err, 0);
        check("rst2_cl", mode_cl, 2);
        drive(C_RD, 2'd0, 13'd0, 16'd0);
        nop();
        check("uninit_err", err, 1);
        check("uninit_code", err_code, 1);
        check("uninit_init", init_done, 0);
        do_reset();
        do_init();
        drive(C_RD, 2'd2, 13'h005, 16'd0);
        nop();
        check("closed_code", err_code, 2);
        check("closed_oe1", sd_data_oe, 0);
        nop();
        check("closed_oe2", sd_data_oe, 0);
        nop();
        check("closed_oe3", sd_data_oe, 0);

        // 5: REF with a bank open; reset during read
        do_reset();
        do_init();
        drive(C_ACT, 2'd0, 13'd7, 16'd0);
        nop(); nop(); nop();
        drive(C_REF, 2'd0, 13'd0, 16'd0);
        nop();
        check("ref_open_code", err_code, 4);
        drive(C_WR, 2'd0, 13'h020, 16'hA5A5);
        drive(C_RD, 2'd0, 13'h020, 16'd0);
        nop();
        nop();
        check("pre_rst_oe", sd_data_oe, 1);
        check("pre_rst_data", sd_data_out, 16'hA5A5);
        #1 reset_n = 1'b0;
        #1;
        check("async_oe", sd_data_oe, 0);
        check("async_dout", sd_data_out, 0);
        check("async_err", err, 0);
        check("async_code", err_code, 0);
        check("async_init", init_done, 0);
        check("async_cl", mode_cl, 2);
        @(negedge clk);
        reset_n = 1'b1;
        do_init();
        drive(C_ACT, 2'd0, 13'd7, 16'd0);
        nop(); nop(); nop();
        drive(C_RD, 2'd0, 13'h020, 16'd0);
        nop();
        #1 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("drop_oe1", sd_data_oe, 0);
        nop();
        check("drop_oe2", sd_data_oe, 0);
        nop();
        check("drop_oe3", sd_data_oe, 0);

        // 6: RD one cycle after ACT (tRCD), data still returned
        do_reset();
        do_init();
        drive(C_ACT, 2'd0, 13'd7, 16'd0);
        drive(C_RD, 2'd0, 13'h020, 16'd0);
        nop();
        nop();
        check("trcd_oe", sd_data_oe, 1);
        check("trcd_data", sd_data_out, 16'hA5A5);
        check("trcd_err", err, TCHK);
        check("trcd_code", err_code, TCHK ? 32'd6 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
